dot_product_accumulator: RTL and testbench

Streaming accumulator placed directly downstream of the 8-lane byte dot-product stage. It consumes one 19-bit unsigned dot product per handshake and sums a packet of beats, delimited by `in_last` or by a beat limit, into a wide result. This turns the single-vector dot product into a length-N (N = 8 × beats) dot product for matrix-vector rows. The result is presented on a registered valid/ready output, so the next packet can accumulate while the previous result is still waiting for the consumer.

---
 rtl/dot_acc_pkg.sv | 13 +
 rtl/dot_acc_adder.sv | 29 ++
 rtl/dot_product_accumulator.sv | 108 ++++++++++
 tb/tb_dot_product_accumulator.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and default widths for the dot-product accumulator.
// Contents: acc_state_e (EMPTY / ACCUM) and the default data widths.
package dot_acc_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    localparam int DOT_IN_WIDTH  = 19;
    localparam int DOT_ACC_WIDTH = 32;

endpackage

// File: rtl/dot_acc_adder.sv
// Combinational ACC_WIDTH+1 adder with carry out for the accumulator.
// Ports: base (running sum), addend (unsigned beat), sum, carry.
// DOT_ACC_SATURATE_EN defined: sum clamps to all-ones on carry.
module dot_acc_adder
    import dot_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DOT_IN_WIDTH,
    parameter int ACC_WIDTH = DOT_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] base,
    input  logic [IN_WIDTH-1:0]  addend,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);

    logic [ACC_WIDTH:0] wide;

    assign wide  = {1'b0, base} + (ACC_WIDTH+1)'(addend);
    assign carry = wide[ACC_WIDTH];

`ifdef DOT_ACC_SATURATE_EN
    // Once clamped, later beats keep it at all-ones: adding zero
    // yields all-ones, anything else carries again.
    assign sum = carry ? '1 : wide[ACC_WIDTH-1:0];
`else
    assign sum = wide[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums packets of unsigned dot products into a registered result.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data/in_last,
// in_flush, out_valid/out_ready/out_data/out_count/out_overflow.
// Macro DOT_ACC_SATURATE_EN selects clamping instead of wrapping.
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DOT_IN_WIDTH,
    parameter int ACC_WIDTH = DOT_ACC_WIDTH,
    parameter int MAX_BEATS = 256,
    parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 in_flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BEATS);

    acc_state_e           state;
    acc_state_e           state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 ovf;
    logic                 ovf_next;
    logic                 carry;
    logic                 accept;
    logic                 term;

    // A held result only blocks input while the consumer stalls.
    assign in_ready = !in_flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // EMPTY means the stored partial is stale: start from zero.
    assign acc_base = (state == EMPTY) ? '0 : acc;
    assign cnt_next = ((state == EMPTY) ? '0 : cnt) + CNT_WIDTH'(1);
    assign ovf_next = carry || ((state == ACCUM) && ovf);
    assign term     = accept && (in_last || (cnt_next == CNT_MAX));

    dot_acc_adder #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_adder (
        .base   (acc_base),
        .addend (in_data),
        .sum    (acc_next),
        .carry  (carry)
    );

    always_comb begin
        state_next = state;
        if (in_flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = term ? EMPTY : ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept && !term) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

    // A termination in the same cycle as a drain reloads in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (term) begin
            out_valid    <= 1'b1;
            out_data     <= acc_next;
            out_count    <= cnt_next;
            out_overflow <= ovf_next;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator: three instances
// (default, MAX_BEATS=4, 20-bit accumulator) driven one at a time.
module tb_dot_product_accumulator;

    typedef struct {
        logic [31:0] data;
        logic [8:0]  count;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    int          sel;
    logic [19:0] in_data;
    logic        in_last;
    logic        in_flush;
    logic        out_ready;

    logic        va, vb, vc;
    logic        ra, rb, rc;
    logic        ov_a, ov_b, ov_c;
    logic [31:0] od_a, od_b;
    logic [19:0] od_c;
    logic [8:0]  oc_a, oc_c;
    logic [2:0]  oc_b;
    logic        of_a, of_b, of_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign va = in_valid && (sel == 0);
    assign vb = in_valid && (sel == 1);
    assign vc = in_valid && (sel == 2);

    dot_product_accumulator dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(va), .in_ready(ra),
        .in_data(in_data[18:0]), .in_last(in_last),
        .in_flush(in_flush),
        .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_count(oc_a),
        .out_overflow(of_a)
    );

    dot_product_accumulator #(.MAX_BEATS(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vb), .in_ready(rb),
        .in_data(in_data[18:0]), .in_last(in_last),
        .in_flush(in_flush),
        .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_count(oc_b),
        .out_overflow(of_b)
    );

    dot_product_accumulator #(.IN_WIDTH(20), .ACC_WIDTH(20)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vc), .in_ready(rc),
        .in_data(in_data), .in_last(in_last),
        .in_flush(in_flush),
        .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_count(oc_c),
        .out_overflow(of_c)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data,
                        input logic [8:0] count, input logic ovf);
        exp_t e;
        e.data  = data;
        e.count = count;
        e.ovf   = ovf;
        case (d)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    function automatic logic ready_of(input int d);
        case (d)
            0: return ra;
            1: return rb;
            default: return rc;
        endcase
    endfunction

    task automatic send(input int d, input logic [19:0] data,
                        input logic last);
        logic rdy;
        bit   done;
        done     = 0;
        sel      = d;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            rdy = ready_of(d);
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && ov_a && out_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_extra: got 0x%0h expected none", od_a);
            end else begin
                e = q_a.pop_front();
                chk("a_data", od_a, e.data);
                chk("a_count", 32'(oc_a), 32'(e.count));
                chk("a_ovf", 32'(of_a), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && ov_b && out_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_extra: got 0x%0h expected none", od_b);
            end else begin
                e = q_b.pop_front();
                chk("b_data", od_b, e.data);
                chk("b_count", 32'(oc_b), 32'(e.count));
                chk("b_ovf", 32'(of_b), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst_n && ov_c && out_ready) begin
            if (q_c.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL c_extra: got 0x%0h expected none", od_c);
            end else begin
                e = q_c.pop_front();
                chk("c_data", 32'(od_c), e.data);
                chk("c_count", 32'(oc_c), 32'(e.count));
                chk("c_ovf", 32'(of_c), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = 0;
        in_data   = '0;
        in_last   = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", 32'(ov_a), 0);
        chk("rst_data_a", od_a, 0);
        chk("rst_count_a", 32'(oc_a), 0);
        chk("rst_ovf_a", 32'(of_a), 0);
        chk("rst_valid_b", 32'(ov_b), 0);
        chk("rst_valid_c", 32'(ov_c), 0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst_a", 32'(ra), 1);
        chk("rdy_after_rst_c", 32'(rc), 1);
        @(posedge clk);
        #1;

        // 1+2+3+4, result visible right after the last beat's edge
        push(0, 10, 4, 0);
        send(0, 1, 0);
        send(0, 2, 0);
        send(0, 3, 0);
        send(0, 4, 1);
        chk("latency_valid", 32'(ov_a), 1);

        // back-to-back packets at full rate
        push(0, 30, 2, 0);
        push(0, 32'h7FFFF, 1, 0);
        send(0, 10, 0);
        send(0, 20, 1);
        send(0, 20'h7FFFF, 1);
        repeat (2) @(posedge clk);
        #1;

        // back-pressure: hold result for 5 cycles
        out_ready = 1'b0;
        push(0, 5, 1, 0);
        send(0, 5, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(ra), 0);
            chk("bp_valid", 32'(ov_a), 1);
            chk("bp_data", od_a, 5);
            @(posedge clk);
            #1;
        end
        // drain and terminate in the same cycle
        out_ready = 1'b1;
        push(0, 9, 1, 0);
        send(0, 9, 1);
        chk("reload_valid", 32'(ov_a), 1);
        chk("reload_data", od_a, 9);
        repeat (2) @(posedge clk);
        #1;

        // flush discards 3+5 and blocks the beat presented with it
        push(0, 7, 1, 0);
        send(0, 3, 0);
        send(0, 5, 0);
        sel      = 0;
        in_data  = 100;
        in_valid = 1'b1;
        in_flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(ra), 0);
        @(posedge clk);
        #1;
        in_flush = 1'b0;
        in_valid = 1'b0;
        send(0, 7, 1);
        repeat (2) @(posedge clk);
        #1;

        // async reset while a result is held
        out_ready = 1'b0;
        send(0, 20'h55, 1);
        chk("held_before_rst", 32'(ov_a), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov_a), 0);
        chk("arst_data", od_a, 0);
        chk("arst_count", 32'(oc_a), 0);
        chk("arst_ovf", 32'(of_a), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // async reset mid-packet drops the partial
        out_ready = 1'b1;
        send(0, 20'h20, 0);
        #3;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 6, 1, 0);
        send(0, 6, 1);
        repeat (2) @(posedge clk);
        #1;

        // beat limit 4: six beats, auto-terminate then a 2-beat packet
        push(1, 32'h1FFFFC, 4, 0);
        push(1, 32'hFFFFE, 2, 0);
        for (int i = 0; i < 6; i++) begin
            send(1, 20'h7FFFF, (i == 5));
        end
        repeat (2) @(posedge clk);
        #1;

        // 20-bit accumulator overflow, wrap vs saturate
`ifdef DOT_ACC_SATURATE_EN
        push(2, 32'hFFFFF, 2, 1);
        push(2, 32'hFFFFF, 3, 1);
`else
        push(2, 32'h00001, 2, 1);
        push(2, 32'h00001, 3, 1);
`endif
        push(2, 32'hFFFFF, 2, 0);
        send(2, 20'hFFFFF, 0);
        send(2, 20'h00002, 1);
        send(2, 20'hFFFFF, 0);
        send(2, 20'h00002, 0);
        send(2, 20'h00000, 1);
        send(2, 20'h80000, 0);
        send(2, 20'h7FFFF, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        chk("drain_c", q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
